// File: rtl/data_mem_banked_pkg.sv
// Shared definitions for the banked data memory: access-size encodings,
// FSM state type and size helpers used by the top and the load extender.
// No logic of its own; latency/backpressure are properties of the users.
package data_mem_banked_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Number of bytes touched by an access; 0 marks the illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Right-aligned byte-enable mask for an access of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Load lane-select and sign/zero extension for the banked data memory.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: lo_word/hi_word = word holding the first byte and the word after it,
//        off = byte offset in lo_word, size/sgn = access size and signedness,
//        data = right-aligned, extended load result.
module mem_extend
  import data_mem_banked_pkg::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [63:0] cat;
  logic [31:0] raw;

  always_comb begin
    // Little-endian: a split access continues from lo_word's top lane into
    // hi_word's bottom lane, so the pair is treated as one 8-byte window.
    cat = {hi_word, lo_word};
    raw = cat[{off, 3'b000} +: 32];
    case (size)
      SZ_BYTE: data = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: data = {{16{sgn & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_banked.sv
// Byte-addressable data memory with byte/half/word loads and stores,
// including accesses that straddle a word boundary (split accesses).
// Latency: 1 cycle for non-split and error responses, 2 cycles for splits.
// Backpressure: req_ready drops only while the second half of a split runs
//               and during rst; responses cannot be stalled.
// Ports: req_* = request handshake and payload, resp_* = one-cycle response.
module data_mem_banked #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  import data_mem_banked_pkg::*;

  localparam int              IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       part_q, part_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [3:0][7:0]   mem_q [DEPTH_WORDS];
  logic [3:0][7:0]   mem_d [DEPTH_WORDS];

  // Current access: the live request in IDLE, the captured one in SPLIT.
  logic [1:0]        c_off, c_size;
  logic [IDX_W-1:0]  c_widx, c_widx_hi;
  logic              c_signed, c_we;
  logic [31:0]       c_wdata;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [31:0]       lo_word, hi_word, ld_data;
  logic [ADDR_W:0]   last_addr;
  logic              accept, legal, is_split;

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    if (state_q == ST_IDLE) begin
      c_off    = req_addr[1:0];
      c_widx   = req_addr[IDX_W+1:2];
      c_size   = req_size;
      c_signed = req_signed;
      c_we     = req_we;
      c_wdata  = req_wdata;
    end else begin
      c_off    = off_q;
      c_widx   = widx_q;
      c_size   = size_q;
      c_signed = signed_q;
      c_we     = we_q;
      c_wdata  = wdata_q;
    end
    c_widx_hi = c_widx + IDX_W'(1);
    // Lanes 0-3 belong to the lower word, lanes 4-7 to the next word.
    be8  = {4'b0000, size_mask(c_size)} << c_off;
    wd64 = {32'b0, c_wdata} << {c_off, 3'b000};
    is_split = |be8[7:4];
    // The lower word is read from storage on the acceptance edge; in SPLIT
    // the pre-store copy held in part_q keeps loads read-before-write.
    lo_word = (state_q == ST_IDLE) ? mem_q[c_widx] : part_q;
    hi_word = mem_q[c_widx_hi];
    // One extra bit so addresses near the top of the space cannot wrap.
    last_addr = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(req_size))
                - (ADDR_W+1)'(1);
    legal = (size_bytes(req_size) != 3'd0) && (last_addr < MEM_BYTES);
  end

  mem_extend u_mem_extend (
    .lo_word (lo_word),
    .hi_word (hi_word),
    .off     (c_off),
    .size    (c_size),
    .sgn     (c_signed),
    .data    (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    widx_d       = widx_q;
    size_d       = size_q;
    signed_d     = signed_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    part_d       = part_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    mem_d        = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!legal) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            if (c_we) begin
              for (int l = 0; l < 4; l++) begin
                if (be8[l]) mem_d[c_widx][l] = wd64[8*l +: 8];
              end
            end
            if (is_split) begin
              state_d  = ST_SPLIT;
              off_d    = c_off;
              widx_d   = c_widx;
              size_d   = c_size;
              signed_d = c_signed;
              we_d     = c_we;
              wdata_d  = c_wdata;
              part_d   = mem_q[c_widx];
            end else begin
              resp_valid_d = 1'b1;
              resp_rdata_d = c_we ? 32'h0 : ld_data;
            end
          end
        end
      end
      ST_SPLIT: begin
        if (we_q) begin
          for (int l = 0; l < 4; l++) begin
            if (be8[l+4]) mem_d[c_widx_hi][l] = wd64[8*(l+4) +: 8];
          end
        end
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? 32'h0 : ld_data;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      widx_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      part_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      widx_q       <= widx_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      part_q       <= part_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_q        <= mem_d;
    end
  end

endmodule
